vproc_dispatcher: RTL

VPROC_DISPATCHER -- requirements
Module: vproc_dispatcher

---
 rtl/vproc_pkg.sv | 66 ++++++
 rtl/vproc_hazard_tracker.sv | 47 ++++
 rtl/vproc_dispatcher.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vproc_pkg.sv
// Shared types and helpers for the vector processor dispatcher.
// Holds the unit encoding, operand descriptors and register-group mask.
package vproc_pkg;

    localparam int NUM_UNITS = 5;

    typedef enum logic [2:0] {
        UNIT_LSU  = 3'd0,
        UNIT_ALU  = 3'd1,
        UNIT_MUL  = 3'd2,
        UNIT_SLD  = 3'd3,
        UNIT_ELEM = 3'd4,
        UNIT_CFG  = 3'd5
    } op_unit;

    typedef logic [3:0] op_mode;

    typedef enum logic [1:0] {
        EMUL_1 = 2'd0,
        EMUL_2 = 2'd1,
        EMUL_4 = 2'd2,
        EMUL_8 = 2'd3
    } cfg_emul;

    typedef struct packed {
        logic       vreg;
        logic [4:0] addr;
    } op_regs;

    typedef struct packed {
        logic       vreg;
        logic [4:0] addr;
    } op_regd;

    typedef struct packed {
        op_unit  unit;
        op_mode  mode;
        cfg_emul emul;
        op_regs  rs1;
        op_regs  rs2;
        op_regd  rd;
    } instr_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } disp_state_e;

    // 2^emul consecutive registers starting at addr aligned down to 2^emul
    function automatic logic [31:0] group_mask(input logic [4:0] addr,
                                               input cfg_emul    emul);
        logic [31:0] ones;
        logic [4:0]  base;
        case (emul)
            EMUL_1:  ones = 32'h0000_0001;
            EMUL_2:  ones = 32'h0000_0003;
            EMUL_4:  ones = 32'h0000_000F;
            EMUL_8:  ones = 32'h0000_00FF;
            default: ones = 32'h0000_0001;
        endcase
        base = addr & ~((5'd1 << emul) - 5'd1);
        return ones << base;
    endfunction

endpackage

// File: rtl/vproc_hazard_tracker.sv
// Pending vector-register write bitmap with set/clear update and
// read/write overlap check of the buffered instruction.
module vproc_hazard_tracker
    import vproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  cfg_emul     emul_i,
    input  op_regs      rs1_i,
    input  op_regs      rs2_i,
    input  op_regd      rd_i,
    input  logic        set_i,
    input  logic [31:0] clr_i,
    output logic [31:0] pend_o,
    output logic        hazard_o
);

    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic [31:0] rs1_mask;
    logic [31:0] rs2_mask;
    logic [31:0] rd_mask;
    logic [31:0] set_mask;

    assign rs1_mask = group_mask(rs1_i.addr, emul_i);
    assign rs2_mask = group_mask(rs2_i.addr, emul_i);
    assign rd_mask  = group_mask(rd_i.addr, emul_i);

    // Checked against the registered bitmap only; a clear lands next cycle
    assign hazard_o = (rs1_i.vreg && (|(rs1_mask & pend_q)))
                   || (rs2_i.vreg && (|(rs2_mask & pend_q)))
                   || (rd_i.vreg && (|(rd_mask & pend_q)));

    assign set_mask = (set_i && rd_i.vreg) ? rd_mask : 32'h0;
    assign pend_d   = (pend_q & ~clr_i) | set_mask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 32'h0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/vproc_dispatcher.sv
// Single-entry instruction buffer that issues to the vector units,
// tracking in-flight count and pending register writes.
module vproc_dispatcher
    import vproc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 15
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  op_unit               instr_unit_i,
    input  op_mode               instr_mode_i,
    input  cfg_emul              instr_emul_i,
    input  op_regs               instr_rs1_i,
    input  op_regs               instr_rs2_i,
    input  op_regd               instr_rd_i,
    output logic [NUM_UNITS-1:0] unit_valid_o,
    input  logic [NUM_UNITS-1:0] unit_ready_i,
    output op_mode               unit_mode_o,
    output cfg_emul              unit_emul_o,
    output op_regs               unit_rs1_o,
    output op_regs               unit_rs2_o,
    output op_regd               unit_rd_o,
    input  logic [NUM_UNITS-1:0] unit_done_i,
    input  logic [31:0]          hazard_clr_i,
    output logic                 cfg_valid_o,
    output logic [31:0]          pend_vreg_o,
    output logic                 idle_o,
    output logic                 error_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int XW = CW + 3;

    disp_state_e          state_q;
    disp_state_e          state_d;
    instr_t               buf_q;
    instr_t               buf_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 hold_v_q;
    logic                 hold_v_d;

    logic [NUM_UNITS-1:0] unit_sel;
    logic [NUM_UNITS-1:0] valid_vec;
    logic [2:0]           done_pop;
    logic                 hazard;
    logic                 illegal;
    logic                 is_cfg;
    logic                 can_issue;
    logic                 issue;
    logic                 drain_fire;
    logic                 err;
    logic                 leaving;
    logic                 accept;
    logic [31:0]          pend;

    vproc_hazard_tracker u_hazard (
        .clk_i    (clk_i),
        .rst_i    (async_rst_i),
        .emul_i   (buf_q.emul),
        .rs1_i    (buf_q.rs1),
        .rs2_i    (buf_q.rs2),
        .rd_i     (buf_q.rd),
        .set_i    (issue),
        .clr_i    (hazard_clr_i),
        .pend_o   (pend),
        .hazard_o (hazard)
    );

    always_comb begin
        unit_sel   = NUM_UNITS'(5'd1 << buf_q.unit);
        illegal    = (buf_q.unit > UNIT_CFG);
        is_cfg     = (buf_q.unit == UNIT_CFG);
        // Once raised, valid stays up until the unit takes it
        can_issue  = hold_v_q || (!hazard && (cnt_q < CW'(MAX_OUTSTANDING)));
        valid_vec  = '0;
        if ((state_q == ST_HOLD) && !illegal && !is_cfg && can_issue) begin
            valid_vec = unit_sel;
        end
        issue      = |(valid_vec & unit_ready_i);
        err        = (state_q == ST_HOLD) && illegal;
        drain_fire = (state_q == ST_DRAIN) && (cnt_q == '0) && (pend == 32'h0);
        leaving    = issue || err || drain_fire;

        instr_ready_o = (state_q == ST_EMPTY) || leaving;
        accept        = instr_valid_i && instr_ready_o;

        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: state_d = ST_EMPTY;
            ST_HOLD: begin
                if (leaving) begin
                    state_d = ST_EMPTY;
                end else if (is_cfg) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        buf_d    = buf_q;
        hold_v_d = (|valid_vec) && !issue;
        if (accept) begin
            state_d  = ST_HOLD;
            hold_v_d = 1'b0;
            buf_d    = '{unit: instr_unit_i,
                         mode: instr_mode_i,
                         emul: instr_emul_i,
                         rs1:  instr_rs1_i,
                         rs2:  instr_rs2_i,
                         rd:   instr_rd_i};
        end

        done_pop = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            done_pop = done_pop + 3'(unit_done_i[i]);
        end
        cnt_d = cnt_q + CW'(issue) - CW'(done_pop);
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q  <= ST_EMPTY;
            buf_q    <= '0;
            cnt_q    <= '0;
            hold_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            hold_v_q <= hold_v_d;
        end
    end

    assign unit_valid_o = valid_vec;
    assign unit_mode_o  = buf_q.mode;
    assign unit_emul_o  = buf_q.emul;
    assign unit_rs1_o   = buf_q.rs1;
    assign unit_rs2_o   = buf_q.rs2;
    assign unit_rd_o    = buf_q.rd;
    assign cfg_valid_o  = drain_fire;
    assign error_o      = err;
    assign pend_vreg_o  = pend;
    assign idle_o       = (state_q == ST_EMPTY) && (cnt_q == '0)
                       && (pend == 32'h0);

    a_cnt_underflow: assert property (
        @(posedge clk_i) disable iff (async_rst_i)
        (XW'(cnt_q) + XW'(issue)) >= XW'(done_pop));

    a_cnt_overflow: assert property (
        @(posedge clk_i) disable iff (async_rst_i)
        (XW'(cnt_q) + XW'(issue)) <= (XW'(MAX_OUTSTANDING) + XW'(done_pop)));

endmodule
